// File: rtl/fnd_scan_ctrl.sv
// LED driver and time-multiplexed active-low 7-segment scanner with hex/decimal display.
// Optional macro FND_BRIGHTNESS_EN adds an 8-bit PWM duty gate on the digit commons.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int LED_W       = 8,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [3:0]            reg_wr,
  input  logic [31:0]           led_reg,
  input  logic [31:0]           fnd_reg,
  input  logic [31:0]           ctrl_reg,
  input  logic [31:0]           div_reg,
  output logic [LED_W-1:0]      led_out,
  output logic [NUM_DIGITS-1:0] fnd_com,
  output logic [7:0]            fnd_seg,
  output logic                  busy,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0]  LAST_IDX = 2'(NUM_DIGITS - 1);
  localparam logic [19:0] DEF_P    = 20'(DEFAULT_DIV);

  state_t           r_state, w_state_nxt;
  logic             r_cap_pend, r_cap_dec;
  logic [15:0]      r_cap_val, r_shift;
  logic [19:0]      r_bcd, w_bcd_adj;
  logic [3:0]       r_cnt;
  logic [3:0][3:0]  r_digit;
  logic             r_ovf, w_ovf;
  logic [19:0]      r_presc, w_period;
  logic [1:0]       r_idx;
  logic             w_cap, w_en, w_dp, w_blank, w_zero_above, w_pwm_on;
  logic [3:0]       w_dp_mask;
  logic [7:0]       w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_com_sel;
  logic             w_unused;

  assign w_cap     = reg_wr[1] | reg_wr[2];
  assign w_en      = ctrl_reg[0];
  assign w_dp_mask = ctrl_reg[7:4];
  assign w_period  = (div_reg[19:0] == 20'd0) ? DEF_P : div_reg[19:0];
  assign w_unused  = ^{led_reg, fnd_reg, ctrl_reg, div_reg, reg_wr};

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Snapshot stage: the pending pulse drives both hex load and conversion start one clock later.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_cap_pend <= 1'b0;
      r_cap_val  <= '0;
      r_cap_dec  <= 1'b0;
      led_out    <= '0;
    end else begin
      r_cap_pend <= w_cap;
      led_out    <= led_reg[LED_W-1:0];
      if (w_cap) begin
        r_cap_val <= fnd_reg[15:0];
        r_cap_dec <= ctrl_reg[1];
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // A fresh snapshot overrides any conversion in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_CONV:  if (r_cnt == 4'd15) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_cap_pend) w_state_nxt = r_cap_dec ? S_CONV : S_IDLE;
  end

  always_comb begin
    w_bcd_adj = '0;
    w_ovf     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
      if (k >= NUM_DIGITS && r_bcd[4*k +: 4] != 4'd0) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else if (r_cap_pend && r_cap_dec) begin
      r_shift <= r_cap_val;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_CONV) begin
      r_bcd   <= {w_bcd_adj[18:0], r_shift[15]};
      r_shift <= {r_shift[14:0], 1'b0};
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  // Displayed buffer changes only as a whole: hex load or a completed, un-aborted conversion.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_digit <= '0;
      r_ovf   <= 1'b0;
    end else if (r_cap_pend && !r_cap_dec) begin
      r_digit <= r_cap_val;
      r_ovf   <= 1'b0;
    end else if (r_state == S_DONE && !r_cap_pend) begin
      r_digit <= r_bcd[15:0];
      r_ovf   <= w_ovf;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (!w_en) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (reg_wr[3]) begin
      r_presc <= '0;
    end else if (r_presc >= w_period - 20'd1) begin
      r_presc <= '0;
      r_idx   <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 20'd1;
    end
  end

`ifdef FND_BRIGHTNESS_EN
  logic [7:0] r_pwm;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_pwm <= '0;
    else                  r_pwm <= r_pwm + 8'd1;
  end
  assign w_pwm_on = (div_reg[27:20] == 8'hFF) || (r_pwm < div_reg[27:20]);
`else
  assign w_pwm_on = 1'b1;
`endif

  always_comb begin
    w_zero_above = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j < NUM_DIGITS && j >= int'(r_idx) && r_digit[j] != 4'd0) w_zero_above = 1'b0;
    end
    w_blank = ctrl_reg[2] && (r_idx != 2'd0) && w_zero_above;
    w_dp    = ~w_dp_mask[r_idx];
    if (r_ovf)        w_seg_nxt = {w_dp, 7'h3F};
    else if (w_blank) w_seg_nxt = {w_dp, 7'h7F};
    else              w_seg_nxt = {w_dp, hex_glyph(r_digit[r_idx])};
    for (int k = 0; k < NUM_DIGITS; k++) w_com_sel[k] = (2'(k) != r_idx);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      fnd_com <= '1;
      fnd_seg <= 8'hFF;
    end else if (!w_en) begin
      fnd_com <= '1;
      fnd_seg <= 8'hFF;
    end else begin
      fnd_com <= w_pwm_on ? w_com_sel : '1;
      fnd_seg <= w_seg_nxt;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed, table-driven bench for fnd_scan_ctrl: scan timing, hex/decimal display,
// conversion latency/abort, blanking, overflow, prescaler clear, reset and brightness gating.
module tb_fnd_scan_ctrl;

  logic        clk, rst_n;
  logic [3:0]  reg_wr;
  logic [31:0] led_reg, fnd_reg, ctrl_reg, div_reg;
  logic [7:0]  led_out;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_seg;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  fnd_scan_ctrl dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .reg_wr         (reg_wr),
    .led_reg        (led_reg),
    .fnd_reg        (fnd_reg),
    .ctrl_reg       (ctrl_reg),
    .div_reg        (div_reg),
    .led_out        (led_out),
    .fnd_com        (fnd_com),
    .fnd_seg        (fnd_seg),
    .busy           (busy),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [15:0] val;
    logic [3:0]  wr;
    logic [31:0] seg;   // digit k expected at seg[8k+:8]
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at a negedge
  task automatic pulse_wr(input logic [3:0] mask);
    reg_wr = mask;
    @(negedge clk);
    reg_wr = 4'b0000;
  endtask

  task automatic rescan();
    ctrl_reg[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ctrl_reg[0] = 1'b1;
  endtask

  task automatic read_digit(input int k, output logic [7:0] seg, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    ok   = 1'b0;
    seg  = 8'h00;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (fnd_com == want) begin
        ok  = 1'b1;
        seg = fnd_seg;
      end
    end
    if (!ok) check($sformatf("digit%0d_timeout", k), {28'h0, fnd_com}, {28'h0, want});
  endtask

  initial begin
    logic [31:0] hex_seg;
    logic [3:0]  exp_com;
    logic [7:0]  seg;
    bit          ok;
    int          d, nb, n80, nact;

    vecs[0] = '{8'h01, 16'h12AF, 4'b0010, 32'hF9A4888E};
    vecs[1] = '{8'h03, 16'd1234, 4'b0010, 32'hF9A4B099};
    vecs[2] = '{8'h07, 16'd42,   4'b0100, 32'hFFFF99A4};
    vecs[3] = '{8'h03, 16'd10000,4'b0010, 32'hBFBFBFBF};
    vecs[4] = '{8'h13, 16'd10000,4'b0110, 32'hBFBFBF3F};
    vecs[5] = '{8'h05, 16'h00C0, 4'b0010, 32'hFFFFC6C0};
    vecs[6] = '{8'h07, 16'd0,    4'b0110, 32'hFFFFFFC0};
    vecs[7] = '{8'hF3, 16'd9999, 4'b0010, 32'h10101010};
    vecs[8] = '{8'h03, 16'd837,  4'b0100, 32'hC080B0F8};
    vecs[9] = '{8'h23, 16'd65535,4'b0010, 32'hBFBF3FBF};

    rst_n = 1'b0; reg_wr = 4'b0; led_reg = 32'h0; fnd_reg = 32'h0; ctrl_reg = 32'h0; div_reg = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_com",   {28'h0, fnd_com}, 32'hF);
    check("rst_seg",   {24'h0, fnd_seg}, 32'hFF);
    check("rst_led",   {24'h0, led_out}, 32'h0);
    check("rst_busy",  {31'h0, busy},    32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // LED path: one-cycle latency
    led_reg = 32'hDEADBEA5;
    #1 check("led_before_edge", {24'h0, led_out}, 32'h00);
    @(negedge clk);
    check("led_a5", {24'h0, led_out}, 32'hA5);
    led_reg = 32'h0000003C;
    @(negedge clk);
    check("led_3c", {24'h0, led_out}, 32'h3C);

    // Hex scan: 4 clocks per digit, digits F, A, 2, 1, then wrap
    div_reg = 32'd4; pulse_wr(4'b1000);
    ctrl_reg = 32'h01; fnd_reg = 32'h12AF; pulse_wr(4'b0010);
    check("hex_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rescan();
    hex_seg = 32'hF9A4888E;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      d = ((i - 1) / 4) % 4;
      exp_com = ~(4'b0001 << d);
      check($sformatf("hex_scan_com_%0d", i), {28'h0, fnd_com}, {28'h0, exp_com});
      check($sformatf("hex_scan_seg_%0d", i), {24'h0, fnd_seg}, {24'h0, hex_seg[8*d +: 8]});
    end

    // Disable blanks within one clock and stays blank
    ctrl_reg = 32'h00;
    @(negedge clk);
    check("dis_com_1clk", {28'h0, fnd_com}, 32'hF);
    check("dis_seg_1clk", {24'h0, fnd_seg}, 32'hFF);
    repeat (5) @(negedge clk);
    check("dis_com_hold", {28'h0, fnd_com}, 32'hF);

    // Decimal latency: busy 17 cycles, digit0 output changes 1 clock after the 18-cycle commit
    ctrl_reg = 32'h01; fnd_reg = 32'h0; pulse_wr(4'b0010);
    div_reg = 32'd100; pulse_wr(4'b1000);
    repeat (2) @(negedge clk);
    rescan();
    repeat (2) @(negedge clk);
    check("dec_setup_seg", {24'h0, fnd_seg}, 32'hC0);
    ctrl_reg = 32'h03; fnd_reg = 32'd1234;
    pulse_wr(4'b0010);
    check("dec_busy_pre", {31'h0, busy}, 32'h0);
    nb = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (i == 5)  check("dec_state_conv", {30'h0, dbg_state}, 32'h1);
      if (i == 17) check("dec_state_done", {30'h0, dbg_state}, 32'h2);
      if (i == 18) begin
        check("dec_busy_end", {31'h0, busy}, 32'h0);
        check("dec_not_early", {24'h0, fnd_seg}, 32'hC0);
      end
      if (i == 19) check("dec_commit", {24'h0, fnd_seg}, 32'h99);
    end
    check("dec_busy_cycles", nb, 32'd17);

    // Abort: 5678 overwritten by 42 mid-conversion; only 42 ever appears
    rescan();
    repeat (2) @(negedge clk);
    check("abort_setup_seg", {24'h0, fnd_seg}, 32'h99);
    fnd_reg = 32'd5678; pulse_wr(4'b0010);
    repeat (5) @(negedge clk);
    fnd_reg = 32'd42; pulse_wr(4'b0010);
    n80 = 0; nb = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (fnd_seg == 8'h80) n80++;
      if (busy) nb++;
      if (i == 18) check("abort_old_held", {24'h0, fnd_seg}, 32'h99);
      if (i == 19) check("abort_commit", {24'h0, fnd_seg}, 32'hA4);
    end
    check("abort_no_stale", n80, 32'd0);
    check("abort_busy_cycles", nb, 32'd17);

    // Table-driven display vectors
    div_reg = 32'd4; pulse_wr(4'b1000);
    for (int v = 0; v < 10; v++) begin
      ctrl_reg = {24'h0, vecs[v].ctrl};
      fnd_reg  = {16'h0, vecs[v].val};
      pulse_wr(vecs[v].wr);
      repeat (22) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        read_digit(k, seg, ok);
        if (ok) check($sformatf("vec%0d_digit%0d", v, k), {24'h0, seg}, {24'h0, vecs[v].seg[8*k +: 8]});
      end
    end

    // Prescaler clear on divider write
    ctrl_reg = 32'h01; fnd_reg = 32'h0; pulse_wr(4'b0010);
    div_reg = 32'd20; pulse_wr(4'b1000);
    rescan();
    repeat (10) @(negedge clk);
    check("presc_pre", {28'h0, fnd_com}, 32'hE);
    div_reg = 32'd3; pulse_wr(4'b1000);
    check("presc_clr_0", {28'h0, fnd_com}, 32'hE);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("presc_clr_%0d", i), {28'h0, fnd_com}, 32'hE);
    end
    @(negedge clk);
    check("presc_advance", {28'h0, fnd_com}, 32'hD);

    // Brightness gating
    div_reg = {4'h0, 8'd64, 20'd4}; pulse_wr(4'b1000);
    nact = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (fnd_com != 4'hF) nact++;
    end
`ifdef FND_BRIGHTNESS_EN
    check("bright_duty64", nact, 32'd64);
`else
    check("bright_ignored", nact, 32'd256);
`endif
    div_reg = {4'h0, 8'd255, 20'd4}; pulse_wr(4'b1000);
    @(negedge clk);
    nact = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (fnd_com != 4'hF) nact++;
    end
    check("bright_duty255", nact, 32'd256);

    // Asynchronous reset mid-scan, then restart from digit0 with a cleared buffer
    div_reg = 32'd4; pulse_wr(4'b1000);
    led_reg = 32'h000000A5;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_com",  {28'h0, fnd_com}, 32'hF);
    check("arst_seg",  {24'h0, fnd_seg}, 32'hFF);
    check("arst_led",  {24'h0, led_out}, 32'h0);
    check("arst_busy", {31'h0, busy},    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp_com = (i <= 4) ? 4'hE : 4'hD;
      check($sformatf("arst_scan_com_%0d", i), {28'h0, fnd_com}, {28'h0, exp_com});
      if (i == 1) check("arst_scan_seg", {24'h0, fnd_seg}, 32'hC0);
    end

    // div field 0 selects DEFAULT_DIV clocks per digit
    div_reg = 32'd0; pulse_wr(4'b1000);
    rescan();
    @(negedge clk);
    nact = 0;
    while (fnd_com == 4'hE && nact < 50010) begin
      nact++;
      @(negedge clk);
    end
    check("default_div_period", nact, 32'd50000);
    check("default_div_next", {28'h0, fnd_com}, 32'hD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Downstream display engine for the led_fnd AXI4-Lite register file. It consumes the four slave registers (LED, FND value, control, scan divider) plus their per-register write strobes. It drives the board LEDs and a time-multiplexed, active-low 7-segment (FND) array. Hex or decimal display; decimal uses an iterative binary-to-BCD converter.

Parameters:
NUM_DIGITS, 4, number of FND digits scanned (1..4)
LED_W, 8, LED output width (1..32)
DEFAULT_DIV, 50000, scan period in clocks per digit used when div_reg[19:0]==0

Ports:
s00_axi_aclk  in  1  system clock (AXI clock)
s00_axi_aresetn  in  1  asynchronous active-low reset
reg_wr  in  4  one-cycle write pulse per register, bit n = slv_reg n written
led_reg  in  32  slv_reg0: [LED_W-1:0] LED pattern
fnd_reg  in  32  slv_reg1: [15:0] display value
ctrl_reg  in  32  slv_reg2: bit0 enable, bit1 decimal mode, bit2 leading-zero blank, [7:4] dp mask (bit4 = digit0)
div_reg  in  32  slv_reg3: [19:0] clocks per digit, [27:20] brightness duty (optional feature)
led_out  out  LED_W  registered LED drive
fnd_com  out  NUM_DIGITS  digit commons, active-low, one-hot-low when lit
fnd_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
busy  out  1  BCD conversion in progress

Behaviour:
- Reset (async assert, sync release): led_out=0, fnd_com=all 1, fnd_seg=8'hFF, busy=0, digit buffer=0, digit index=0, prescaler=0, FSM=IDLE.
- LED path: led_out <= led_reg[LED_W-1:0] every clock (1-cycle latency).
- Value capture: on reg_wr[1] or reg_wr[2], snapshot fnd_reg[15:0] and ctrl_reg[1].
- Hex mode: the digit buffer loads the nibbles on the next clock. Digit k = value[4k+3:4k]. busy stays 0.
- Decimal mode FSM: IDLE -> CONV -> DONE -> IDLE.
  - CONV is double-dabble: 16 iterations, one shift per clock.
  - DONE commits the BCD to the digit buffer. busy=1 in CONV and DONE.
  - Buffer update 18 cycles after the strobe.
- Overflow: in decimal mode, a value >= 10^NUM_DIGITS shows the overflow pattern. Every digit = seg g only (8'hBF, dp per mask).
- Write during CONV/DONE: abort and restart CONV with the new snapshot. Only the last value is committed. The old buffer stays displayed until commit (atomic update; never a partial mix).
- Scan:
  - The prescaler counts 0..P-1, where P = div_reg[19:0], or DEFAULT_DIV if that field is 0.
  - At P-1 the digit index increments and wraps NUM_DIGITS-1 -> 0.
  - reg_wr[3] clears the prescaler to 0 (no overrun when P shrinks).
- Outputs are registered: fnd_com/fnd_seg change 1 clock after the index change. fnd_com[idx]=0, all others 1.
- Segments: standard hex glyphs 0-F, active-low (0 -> 8'hC0, 1 -> F9, ..., F -> 8E). dp segment = ~ctrl_reg[4+idx], live.
- Leading-zero blank (ctrl bit2): digits above the most significant nonzero digit output 8'hFF (dp still applies). Digit 0 is never blanked.
- Disable (ctrl bit0 = 0): fnd_com = all 1, fnd_seg = FF, prescaler and index held at 0. Conversion still runs and the buffer still updates.
- Simultaneous reg_wr[1] and reg_wr[2]: treated as a single capture.

Optional Feature:
FND_BRIGHTNESS_EN:
- Defined: an 8-bit free-running PWM counter runs every clock. fnd_com is active only while pwm_cnt < div_reg[27:20]. Duty 255 = always on; 0 = always off. fnd_seg is unaffected.
- Undefined: full duty, div_reg[27:20] ignored, no PWM counter.

Test Plan:
1. Reset mid-scan: assert aresetn=0 asynchronously -> fnd_com=4'hF, fnd_seg=8'hFF, led_out=0 immediately. After release, scanning restarts at digit0.
2. Hex mode, ctrl=0x01, div=4, fnd_reg=0x12AF:
   - Digit0 shows 8'h8E (F) for 4 clocks, then digit1 A (8'h88), digit2 2 (8'hA4), digit3 1 (8'hF9).
   - Pattern wraps back to digit0.
3. Decimal mode, ctrl=0x03, fnd_reg=1234:
   - busy=1 for 17 cycles and the buffer commits 18 clocks after the strobe.
   - Digits read 4,3,2,1. A second write of 42 during CONV -> only 0042 committed.
   - With ctrl=0x07 -> digits 2,4, then blank FF, FF.
4. Decimal overflow: fnd_reg=10000, ctrl=0x03 -> all digits 8'hBF. dp mask 0x1 (ctrl=0x13) -> digit0 8'h3F.
5. div_reg=0 -> 50000-clock digit period. Write div=3 while prescaler=10 -> prescaler clears, next digit advance after 3 clocks. ctrl=0x00 -> fnd_com=4'hF within 1 clock.
6. FND_BRIGHTNESS_EN, duty=64: fnd_com active 64 of every 256 clocks. Duty=255 -> continuous. Without the macro -> continuous regardless of duty.
